// File: rtl/sdp_core_split.sv
// sdp_core_split: wide-to-narrow splitter on the SDP output path.
// Takes one IW-bit beat plus a per-segment mask and emits only the enabled
// OW-bit segments, lowest index first, one per cycle. out_last flags the
// highest enabled segment of each beat so the DMA side can close its request.
// Optional macro SDP_SPLIT_OUT_PIPE_EN adds a registered output stage; the
// default build drives outputs straight from the hold register.
module sdp_core_split #(
    parameter int IW    = 512,
    parameter int OW    = 128,
    parameter int RATIO = IW / OW
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              inp_pvld,
    output logic              inp_prdy,
    input  logic [IW-1:0]     inp_data,
    input  logic [RATIO-1:0]  inp_mask,
    output logic              out_pvld,
    input  logic              out_prdy,
    output logic [OW-1:0]     out_data,
    output logic [3:0]        out_idx,
    output logic              out_last
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [IW-1:0]     data_r;
    logic [IW-1:0]     data_nxt_s;
    logic [RATIO-1:0]  mask_r;
    logic [RATIO-1:0]  mask_nxt_s;
    logic [RATIO-1:0]  sel_oh_s;
    logic [3:0]        ffs_idx_s;
    logic [OW-1:0]     seg_s;
    logic              last_s;
    logic              hold_vld_s;
    logic              down_rdy_s;
    logic              core_acc_s;
    logic              inp_acc_s;

    // The state always mirrors |mask_r, so the state alone tells us whether the hold register is live.
    assign hold_vld_s = (state_r == ST_SPLIT);
    assign core_acc_s = hold_vld_s & down_rdy_s;
    // A new beat may enter while the last segment of the current one leaves: zero-bubble handoff.
    assign inp_prdy   = (~hold_vld_s) | (core_acc_s & last_s);
    assign inp_acc_s  = inp_pvld & inp_prdy;

    // Find-first-set over the remaining mask; scanning high-to-low lets the lowest set bit win.
    always_comb begin
        ffs_idx_s = 4'd0;
        seg_s     = data_r[OW-1:0];
        for (int k = RATIO - 1; k >= 0; k--) begin
            ffs_idx_s = mask_r[k] ? 4'(k) : ffs_idx_s;
            seg_s     = mask_r[k] ? data_r[k*OW +: OW] : seg_s;
        end
    end

    // Last flag and one-hot clear vector for the currently presented segment.
    always_comb begin
        last_s   = 1'b1;
        sel_oh_s = '0;
        for (int k = 0; k < RATIO; k++) begin
            last_s      = last_s & ~(mask_r[k] & (4'(k) > ffs_idx_s));
            sel_oh_s[k] = (4'(k) == ffs_idx_s);
        end
    end

    // Hold register next value: a new beat overrides the clear of the segment just sent.
    always_comb begin
        data_nxt_s = data_r;
        mask_nxt_s = mask_r;
        if (inp_acc_s) begin
            data_nxt_s = inp_data;
            mask_nxt_s = inp_mask;
        end else if (core_acc_s) begin
            mask_nxt_s = mask_r & ~sel_oh_s;
        end else begin
            mask_nxt_s = mask_r;
        end
    end

    // EMPTY/SPLIT next-state: SPLIT exactly while any segment remains to be sent.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (|mask_nxt_s) begin
                    state_nxt_s = ST_SPLIT;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_SPLIT: begin
                if (|mask_nxt_s) begin
                    state_nxt_s = ST_SPLIT;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // State register; reset discards any partially sent beat.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Hold register for beat data and remaining mask.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            data_r <= '0;
            mask_r <= '0;
        end else begin
            data_r <= data_nxt_s;
            mask_r <= mask_nxt_s;
        end
    end

`ifdef SDP_SPLIT_OUT_PIPE_EN
    logic              pipe_vld_r;
    logic [OW-1:0]     pipe_data_r;
    logic [3:0]        pipe_idx_r;
    logic              pipe_last_r;

    // The splitter advances whenever the output stage can take a new segment.
    assign down_rdy_s = (~pipe_vld_r) | out_prdy;

    // Output stage: payload only moves with a real segment, so it stays stable under backpressure.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            pipe_vld_r  <= 1'b0;
            pipe_data_r <= '0;
            pipe_idx_r  <= 4'd0;
            pipe_last_r <= 1'b1;
        end else if (down_rdy_s) begin
            pipe_vld_r <= hold_vld_s;
            if (hold_vld_s) begin
                pipe_data_r <= seg_s;
                pipe_idx_r  <= ffs_idx_s;
                pipe_last_r <= last_s;
            end
        end
    end

    assign out_pvld = pipe_vld_r;
    assign out_data = pipe_data_r;
    assign out_idx  = pipe_idx_r;
    assign out_last = pipe_last_r;
`else
    assign down_rdy_s = out_prdy;
    assign out_pvld   = hold_vld_s;
    assign out_data   = seg_s;
    assign out_idx    = ffs_idx_s;
    assign out_last   = last_s;
`endif

endmodule

// File: tb/tb_sdp_core_split.sv
// Directed self-checking bench for sdp_core_split (IW=512, OW=128, RATIO=4).
// Output expectations are offset by LAT so the same sequence covers both
// builds (SDP_SPLIT_OUT_PIPE_EN adds one cycle of latency).
module tb_sdp_core_split;

    localparam int IW    = 512;
    localparam int OW    = 128;
    localparam int RATIO = 4;
`ifdef SDP_SPLIT_OUT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              nvdla_core_clk;
    logic              nvdla_core_rstn;
    logic              inp_pvld;
    logic              inp_prdy;
    logic [IW-1:0]     inp_data;
    logic [RATIO-1:0]  inp_mask;
    logic              out_pvld;
    logic              out_prdy;
    logic [OW-1:0]     out_data;
    logic [3:0]        out_idx;
    logic              out_last;

    int checks = 0;
    int errors = 0;

    sdp_core_split #(.IW(IW), .OW(OW), .RATIO(RATIO)) dut (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .inp_pvld        (inp_pvld),
        .inp_prdy        (inp_prdy),
        .inp_data        (inp_data),
        .inp_mask        (inp_mask),
        .out_pvld        (out_pvld),
        .out_prdy        (out_prdy),
        .out_data        (out_data),
        .out_idx         (out_idx),
        .out_last        (out_last)
    );

    initial nvdla_core_clk = 1'b0;
    always #5 nvdla_core_clk = ~nvdla_core_clk;

    function automatic logic [OW-1:0] mkseg(input logic [7:0] b, input int k);
        logic [7:0] v;
        v = b + 8'(k);
        return {16{v}};
    endfunction

    function automatic logic [IW-1:0] mkbeat(input logic [7:0] b);
        logic [IW-1:0] r;
        r = '0;
        for (int k = 0; k < RATIO; k++) begin
            r[k*OW +: OW] = mkseg(b, k);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [OW-1:0] d,
                           input int idx, input logic last);
        chk({tag, "_vld"}, {127'd0, out_pvld}, {127'd0, v});
        if (v) begin
            chk({tag, "_data"}, out_data, d);
            chk({tag, "_idx"}, {124'd0, out_idx}, 128'(idx));
            chk({tag, "_last"}, {127'd0, out_last}, {127'd0, last});
        end
    endtask

    task automatic next_cyc();
        @(negedge nvdla_core_clk);
    endtask

    initial begin
        int e;
        nvdla_core_rstn = 1'b0;
        inp_pvld        = 1'b0;
        inp_data        = '0;
        inp_mask        = 4'h0;
        out_prdy        = 1'b1;
        #1;
        // reset values
        chk("rst_vld", {127'd0, out_pvld}, 128'd0);
        chk("rst_prdy", {127'd0, inp_prdy}, 128'd1);
        chk("rst_data", out_data, 128'd0);
        chk("rst_idx", {124'd0, out_idx}, 128'd0);
        chk("rst_last", {127'd0, out_last}, 128'd1);
        next_cyc();
        nvdla_core_rstn = 1'b1;
        next_cyc();

        // S1: full mask, no backpressure
        for (int c = 0; c <= LAT + 5; c++) begin
            next_cyc();
            inp_pvld = (c == 0);
            inp_data = mkbeat(8'hA0);
            inp_mask = 4'hF;
            out_prdy = 1'b1;
            #1;
            e = c - LAT;
            chk_out("s1", (e >= 0 && e < 4), mkseg(8'hA0, e), e, (e == 3));
            if (c <= 4) chk("s1_prdy", {127'd0, inp_prdy}, {127'd0, (c == 0 || c == 4)});
        end

        // S2: sparse mask 1010
        for (int c = 0; c <= LAT + 2; c++) begin
            next_cyc();
            inp_pvld = (c == 0);
            inp_data = mkbeat(8'hD0);
            inp_mask = 4'b1010;
            #1;
            e = c - LAT;
            chk_out("s2", (e == 0 || e == 1), mkseg(8'hD0, (e == 0) ? 1 : 3),
                    (e == 0) ? 1 : 3, (e == 1));
            if (c >= 1 && c <= 2) chk("s2_prdy", {127'd0, inp_prdy}, {127'd0, (c == 2)});
        end

        // S3: empty mask is dropped, next beat accepted the following cycle
        for (int c = 0; c <= LAT + 2; c++) begin
            next_cyc();
            inp_pvld = (c <= 1);
            inp_data = (c == 0) ? mkbeat(8'hE0) : mkbeat(8'h30);
            inp_mask = (c == 0) ? 4'h0 : 4'h1;
            #1;
            if (c <= 1) chk("s3_prdy", {127'd0, inp_prdy}, 128'd1);
            chk_out("s3", (c == 1 + LAT), mkseg(8'h30, 0), 0, 1'b1);
        end

        // S4: backpressure for 3 cycles after the first segment
        for (int c = 0; c <= LAT + 7; c++) begin
            next_cyc();
            inp_pvld = (c == 0);
            inp_data = mkbeat(8'hB0);
            inp_mask = 4'hF;
            out_prdy = !(c >= LAT + 1 && c <= LAT + 3);
            #1;
            e = c - LAT;
            if (e < 0 || e > 6) begin
                chk_out("s4", 1'b0, '0, 0, 1'b0);
            end else if (e == 0) begin
                chk_out("s4", 1'b1, mkseg(8'hB0, 0), 0, 1'b0);
            end else if (e <= 4) begin
                chk_out("s4", 1'b1, mkseg(8'hB0, 1), 1, 1'b0);
            end else begin
                chk_out("s4", 1'b1, mkseg(8'hB0, e - 3), e - 3, (e == 6));
            end
        end
        out_prdy = 1'b1;

        // S5: two back-to-back beats, no bubble
        for (int c = 0; c <= LAT + 8; c++) begin
            next_cyc();
            inp_pvld = (c <= 4);
            inp_data = (c == 0) ? mkbeat(8'h10) : mkbeat(8'h50);
            inp_mask = 4'hF;
            #1;
            e = c - LAT;
            chk_out("s5", (e >= 0 && e < 8),
                    (e < 4) ? mkseg(8'h10, e) : mkseg(8'h50, e - 4), e % 4, (e % 4 == 3));
            if (c <= 4) chk("s5_prdy", {127'd0, inp_prdy}, {127'd0, (c == 0 || c == 4)});
        end

        // S6: asynchronous reset mid-beat, then a single-segment beat
        for (int c = 0; c <= 2; c++) begin
            next_cyc();
            inp_pvld = (c == 0);
            inp_data = mkbeat(8'h60);
            inp_mask = 4'hF;
            #1;
        end
        next_cyc();
        nvdla_core_rstn = 1'b0;
        #1;
        chk("s6_rst_vld", {127'd0, out_pvld}, 128'd0);
        chk("s6_rst_prdy", {127'd0, inp_prdy}, 128'd1);
        chk("s6_rst_data", out_data, 128'd0);
        chk("s6_rst_last", {127'd0, out_last}, 128'd1);
        next_cyc();
        nvdla_core_rstn = 1'b1;
        #1;
        chk("s6_idle_vld", {127'd0, out_pvld}, 128'd0);
        for (int c = 0; c <= LAT + 1; c++) begin
            next_cyc();
            inp_pvld = (c == 0);
            inp_data = mkbeat(8'h70);
            inp_mask = 4'b0100;
            #1;
            e = c - LAT;
            chk_out("s6", (e == 0), mkseg(8'h70, 2), 2, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdp_core_split.md
Name: sdp_core_split

Overview:
- Wide-to-narrow splitter on the SDP output path; mirror of the narrow-to-wide packer stage.
- Accepts one IW-bit beat with a per-segment valid mask and emits only the enabled OW-bit segments, lowest index first, one per cycle.
- Feeds the narrower DMA write interface.
- Marks the last emitted segment of each beat so downstream can close the request.

Parameters:
IW, 512, input beat width in bits
OW, 128, output segment width in bits
RATIO, IW/OW, segments per beat; legal values 1, 2, 4, 8, 16; any other value is unsupported

Ports:
nvdla_core_clk  input  1  core clock
nvdla_core_rstn  input  1  reset; asynchronous, active-low
inp_pvld  input  1  input beat valid
inp_prdy  output  1  input beat ready
inp_data  input  IW  beat; segment k = inp_data[k*OW +: OW]
inp_mask  input  RATIO  bit k set = segment k is emitted
out_pvld  output  1  output segment valid
out_prdy  input  1  output segment ready
out_data  output  OW  selected segment
out_idx  output  4  index of the segment currently presented
out_last  output  1  presented segment is the highest set mask bit of its beat

Behaviour:
- Storage: hold register (IW data + RATIO remaining-mask) plus hold_vld.
  - hold_vld = |remaining-mask.
  - States: EMPTY (hold_vld=0) and SPLIT (hold_vld=1).
- inp_acc = inp_pvld & inp_prdy; out_acc = out_pvld & out_prdy.
- inp_prdy = !hold_vld | (out_acc & out_last). Combinational; allows zero-bubble beat-to-beat handoff.
- On inp_acc: data and remaining-mask load from inp_data and inp_mask.
  - inp_mask==0: beat is consumed and dropped; state becomes/stays EMPTY; no output produced.
- Segment select: out_idx = find-first-set (lowest index) of remaining-mask.
  - out_data = hold segment out_idx.
  - out_last = no set bit above out_idx.
- On out_acc without inp_acc: clear bit out_idx in remaining-mask; clearing the last bit returns to EMPTY.
- On out_acc & out_last & inp_acc in the same cycle: the new beat load wins; SPLIT continues with the new mask.
- out_pvld = hold_vld.
- Latency: beat accepted in cycle N, first segment presented in N+1. Throughput: one segment per cycle under no backpressure.
- Backpressure: while out_pvld & !out_prdy, out_data, out_idx and out_last are held stable. Hold register never changes without out_acc or inp_acc.
- RATIO==1: out_idx=0, out_last=1 whenever valid; pass-through with 1-cycle latency.
- Reset values: hold_vld=0, remaining-mask=0, data=0. Therefore out_pvld=0, out_data=0, out_idx=0, out_last=1 (no higher bits set), inp_prdy=1.
- Reset asserted mid-beat: outputs go to reset values immediately (asynchronous) and remaining segments are discarded. After release, the block waits in EMPTY.
- Width: out_idx zero-extended to 4 bits for RATIO<16.

Optional Feature:
- Macro: SDP_SPLIT_OUT_PIPE_EN.
- Defined:
  - Adds a registered output stage; out_pvld/out_data/out_idx/out_last come from flops.
  - Stage loads when !pipe_vld | out_prdy; internal ready = !pipe_vld | out_prdy.
  - Latency becomes 2 cycles (accept N, first segment N+2); throughput remains one segment per cycle.
  - Pipe flops reset to the same values listed above.
- Undefined: outputs are driven combinationally from the hold register as described.

Test Plan:
- RATIO=4, mask 4'hF, segments A0..A3, out_prdy=1, accept in cycle 0 -> out_data A0,A1,A2,A3 with out_idx 0..3 in cycles 1..4; out_last only in cycle 4; inp_prdy low in cycles 1..3, high in cycle 4.
- Mask 4'b1010 -> exactly two segments: seg1 (idx 1, last=0) then seg3 (idx 3, last=1); beat fully consumed after 2 out_acc.
- Mask 4'h0 with inp_pvld=1 -> inp_prdy stays 1, out_pvld stays 0, next beat accepted the following cycle.
- Mask 4'hF with out_prdy low for 3 cycles after the first segment -> seg1 with idx 1 held stable for 3 cycles; all four segments delivered in order with no duplicates.
- Two back-to-back beats, both mask 4'hF, with inp_pvld held high -> 8 consecutive out_acc cycles with no bubble; second beat accepted in the cycle of the first beat's out_last.
- Reset asserted after 2 of 4 segments -> out_pvld=0, inp_prdy=1 immediately. Next beat with mask 4'b0100 emits only seg2 with out_last=1.
- Repeat the first and fourth scenarios with SDP_SPLIT_OUT_PIPE_EN defined -> same order and values, each shifted one cycle later.
